// File: rtl/vram_write_scheduler.sv
// Video-memory write scheduler: queues core writes in a small FIFO and interleaves
// them fairly with a hardware fill engine onto a single registered VRAM write port.
module vram_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_data,
  input  logic             fill_start,
  input  logic [31:0]      fill_base,
  input  logic [CNT_W-1:0] fill_count,
  input  logic [31:0]      fill_color,
  input  logic             overflow_clr,
  output logic             vm_we,
  output logic [31:0]      vm_addr,
  output logic [31:0]      vm_data,
  output logic             fill_busy,
  output logic             fill_done,
  output logic             fifo_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fill_state_e;
  typedef enum logic {G_CORE, G_FILL} grant_e;

  // FIFO storage and bookkeeping
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Fill engine
  fill_state_e      state_q, state_d;
  logic [31:0]      fill_addr_q, fill_addr_d;
  logic [CNT_W-1:0] fill_rem_q, fill_rem_d;
  logic [31:0]      fill_color_q, fill_color_d;

  // Arbiter and registered write port
  grant_e           last_grant_q, last_grant_d;
  logic             vm_we_q, vm_we_d;
  logic [31:0]      vm_addr_q, vm_addr_d;
  logic [31:0]      vm_data_q, vm_data_d;

  logic fifo_empty, fifo_full, core_req, fill_req;
  logic grant_core, grant_fill, push, pop, ovf_set;
  logic [63:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign core_req   = !fifo_empty;
  assign fill_req   = (state_q == S_RUN);

  // On a tie the requester that lost the previous grant wins.
  assign grant_core = core_req && (!fill_req || last_grant_q == G_FILL);
  assign grant_fill = fill_req && (!core_req || last_grant_q == G_CORE);

  // A pop on a full FIFO frees the slot for a same-cycle push.
  assign pop     = grant_core;
  assign push    = core_we && (!fifo_full || pop);
  assign ovf_set = core_we && fifo_full && !pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    vm_we_d      = grant_core || grant_fill;
    vm_addr_d    = vm_addr_q;
    vm_data_d    = vm_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + (PTR_W + 1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PTR_W + 1)'(1);

    ovf_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

    if (grant_core) begin
      last_grant_d = G_CORE;
      vm_addr_d    = head[63:32];
      vm_data_d    = head[31:0];
    end else if (grant_fill) begin
      last_grant_d = G_FILL;
      vm_addr_d    = fill_addr_q;
      vm_data_d    = fill_color_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_rem_d   = fill_rem_q;
    fill_color_d = fill_color_q;
    unique case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          if (fill_count != '0) begin
            fill_addr_d  = fill_base;
            fill_rem_d   = fill_count;
            fill_color_d = fill_color;
            state_d      = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (grant_fill) begin
          fill_addr_d = fill_addr_q + 32'd4;
          fill_rem_d  = fill_rem_q - CNT_W'(1);
          if (fill_rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; emptying the FIFO via the pointers and count makes its contents don't-care.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {core_addr, core_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      state_q      <= S_IDLE;
      fill_addr_q  <= '0;
      fill_rem_q   <= '0;
      fill_color_q <= '0;
      last_grant_q <= G_FILL;
      vm_we_q      <= 1'b0;
      vm_addr_q    <= '0;
      vm_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_rem_q   <= fill_rem_d;
      fill_color_q <= fill_color_d;
      last_grant_q <= last_grant_d;
      vm_we_q      <= vm_we_d;
      vm_addr_q    <= vm_addr_d;
      vm_data_q    <= vm_data_d;
    end
  end

  assign vm_we         = vm_we_q;
  assign vm_addr       = vm_addr_q;
  assign vm_data       = vm_data_q;
  assign fill_busy     = (state_q != S_IDLE);
  assign fill_done     = (state_q == S_DONE);
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler: expected core and fill writes are queued
// when driven and compared as they appear on the VRAM port.
module tb_vram_write_scheduler;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             core_we = 1'b0;
  logic [31:0]      core_addr = '0;
  logic [31:0]      core_data = '0;
  logic             fill_start = 1'b0;
  logic [31:0]      fill_base = '0;
  logic [CNT_W-1:0] fill_count = '0;
  logic [31:0]      fill_color = '0;
  logic             overflow_clr = 1'b0;
  logic             vm_we;
  logic [31:0]      vm_addr;
  logic [31:0]      vm_data;
  logic             fill_busy;
  logic             fill_done;
  logic             fifo_overflow;

  vram_write_scheduler #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_addr(core_addr), .core_data(core_data),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_color(fill_color), .overflow_clr(overflow_clr),
    .vm_we(vm_we), .vm_addr(vm_addr), .vm_data(vm_data),
    .fill_busy(fill_busy), .fill_done(fill_done), .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] core_q[$];
  logic [63:0] fill_q[$];
  logic [63:0] delivered[$];
  int          kinds[$];
  bit          sub_mode = 1'b0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (fill_done) done_cnt++;
    if (vm_we) begin
      if (sub_mode && vm_data[31:16] == 16'hC0DE) begin
        delivered.push_back({vm_addr, vm_data});
      end else if (core_q.size() != 0 && {vm_addr, vm_data} == core_q[0]) begin
        check("core_wr", {vm_addr, vm_data}, core_q.pop_front());
        kinds.push_back(1);
      end else if (fill_q.size() != 0) begin
        check("fill_wr", {vm_addr, vm_data}, fill_q.pop_front());
        kinds.push_back(0);
      end else begin
        check("spurious_we", 64'(vm_we), 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic [31:0] a, input logic [31:0] d);
    core_we   = 1'b1;
    core_addr = a;
    core_data = d;
    if (!sub_mode) core_q.push_back({a, d});
    tick();
  endtask

  task automatic start_fill(input logic [31:0] base, input int cnt, input logic [31:0] color);
    fill_start = 1'b1;
    fill_base  = base;
    fill_count = CNT_W'(cnt);
    fill_color = color;
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      fill_q.push_back({a, color});
    end
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      if (core_q.size() == 0 && fill_q.size() == 0 && !fill_busy) break;
      tick();
    end
    check(tag, 64'(i < max_cycles), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done;
    int prev;
    int idx;

    // Reset state
    #7;
    check("rst_vm_we",   64'(vm_we), 64'h0);
    check("rst_vm_addr", 64'(vm_addr), 64'h0);
    check("rst_vm_data", 64'(vm_data), 64'h0);
    check("rst_busy",    64'(fill_busy), 64'h0);
    check("rst_done",    64'(fill_done), 64'h0);
    check("rst_ovf",     64'(fifo_overflow), 64'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Single core write latency: pushed at end of cycle 0, visible only in cycle 2
    drive_core(32'h8000_0010, 32'h00FF_00FF);
    core_we = 1'b0;
    @(negedge clk);
    check("lat_c1_we", 64'(vm_we), 64'h0);
    @(negedge clk);
    check("lat_c2_we",   64'(vm_we), 64'h1);
    check("lat_c2_addr", 64'(vm_addr), 64'h8000_0010);
    check("lat_c2_data", 64'(vm_data), 64'h00FF_00FF);
    @(negedge clk);
    check("lat_c3_we",   64'(vm_we), 64'h0);
    check("lat_c3_hold", 64'(vm_addr), 64'h8000_0010);
    tick();

    // Fill of 3 words; a second fill_start during RUN is ignored
    base_done = done_cnt;
    start_fill(32'h8000_0000, 3, 32'h1234_5678);
    @(negedge clk);
    check("fill3_busy", 64'(fill_busy), 64'h1);
    fill_start = 1'b1;
    fill_base  = 32'h5000_0000;
    fill_count = CNT_W'(5);
    tick();
    fill_start = 1'b0;
    wait_drain("fill3_drain", 50);
    repeat (2) tick();
    check("fill3_done_cnt", 64'(done_cnt - base_done), 64'd1);
    check("fill3_busy_end", 64'(fill_busy), 64'h0);

    // Zero-count fill: straight to DONE, no writes
    base_done = done_cnt;
    start_fill(32'h9000_0000, 0, 32'hDEAD_0000);
    @(negedge clk);
    check("fill0_done", 64'(fill_done), 64'h1);
    @(negedge clk);
    check("fill0_done_low", 64'(fill_done), 64'h0);
    check("fill0_busy_low", 64'(fill_busy), 64'h0);
    tick();
    check("fill0_done_cnt", 64'(done_cnt - base_done), 64'd1);

    // Fill of 8 with two back-to-back core writes: core wins the first tie, then alternates
    kinds.delete();
    start_fill(32'h8000_0100, 8, 32'hAAAA_5555);
    drive_core(32'h1000_0000, 32'hA1A1_A1A1);
    drive_core(32'h1000_0004, 32'hA2A2_A2A2);
    core_we = 1'b0;
    wait_drain("alt_drain", 60);
    repeat (2) tick();
    check("alt_total", 64'(kinds.size()), 64'd10);
    if (kinds.size() >= 4) begin
      check("alt_k0_fill", 64'(kinds[0]), 64'd0);
      check("alt_k1_core", 64'(kinds[1]), 64'd1);
      check("alt_k2_fill", 64'(kinds[2]), 64'd0);
      check("alt_k3_core", 64'(kinds[3]), 64'd1);
    end

    // Address wrap across 2^32
    start_fill(32'hFFFF_FFFC, 2, 32'h0BAD_F00D);
    wait_drain("wrap_drain", 30);
    repeat (2) tick();

    // Overflow: long fill while the core outpaces its half of the bandwidth
    sub_mode = 1'b1;
    delivered.delete();
    start_fill(32'h2000_0000, 100, 32'h5A5A_5A5A);
    for (int i = 0; i < 12; i++) drive_core(32'h3000_0000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    core_we = 1'b0;
    @(negedge clk);
    check("ovf_set", 64'(fifo_overflow), 64'h1);
    wait_drain("ovf_drain", 400);
    repeat (3) tick();
    check("ovf_sticky", 64'(fifo_overflow), 64'h1);
    check("ovf_dropped", 64'(delivered.size() < 12 && delivered.size() > 0), 64'd1);
    prev = -1;
    foreach (delivered[k]) begin
      idx = int'(delivered[k][15:0]);
      check("ovf_order", 64'(idx > prev), 64'd1);
      check("ovf_addr", 64'(delivered[k][63:32]), 64'(32'h3000_0000 + 32'(4 * idx)));
      prev = idx;
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(fifo_overflow), 64'h0);
    sub_mode = 1'b0;
    tick();

    // Reset during RUN with queued core writes
    start_fill(32'h4000_0000, 20, 32'h0000_0077);
    drive_core(32'h5000_0000, 32'h5555_0001);
    drive_core(32'h5000_0004, 32'h5555_0002);
    drive_core(32'h5000_0008, 32'h5555_0003);
    core_we = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mrst_vm_we",   64'(vm_we), 64'h0);
    check("mrst_vm_addr", 64'(vm_addr), 64'h0);
    check("mrst_vm_data", 64'(vm_data), 64'h0);
    check("mrst_busy",    64'(fill_busy), 64'h0);
    check("mrst_done",    64'(fill_done), 64'h0);
    check("mrst_ovf",     64'(fifo_overflow), 64'h0);
    core_q.delete();
    fill_q.delete();
    base_done = done_cnt;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (30) tick();
    check("mrst_no_done", 64'(done_cnt - base_done), 64'd0);
    check("mrst_idle",    64'(fill_busy), 64'h0);

    // Normal operation after reset release
    drive_core(32'h6000_0000, 32'hDEAD_BEEF);
    core_we = 1'b0;
    start_fill(32'h7000_0000, 2, 32'h0F0F_0F0F);
    wait_drain("post_rst_drain", 40);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
